// File: rtl/jimmy_port_pkg.sv
// jimmy_port_pkg
//   Shared definitions for the jimmy port RAM responder: command codes seen on
//   the core's out_port_3, out_strobe bit positions, status_out bit positions
//   and the responder FSM state encoding.
package jimmy_port_pkg;

    // Command codes written by the core to out_port_3
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h03;
    localparam logic [7:0] CMD_ACK   = 8'h04;

    // out_strobe bit positions (bit 0 belongs to out_port_0, not used here)
    localparam int STB_LO    = 1;
    localparam int STB_ADDR  = 1;
    localparam int STB_WDATA = 2;
    localparam int STB_CMD   = 3;
    localparam int STB_N     = 3;   // number of strobes this block watches

    // status_out bit positions; [7:5] always read as zero
    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_ERR_CMD   = 2;
    localparam int ST_ERR_RANGE = 3;
    localparam int ST_OVERRUN   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_CLR  = 2'd3
    } state_t;

endpackage

// File: rtl/jimmy_port_ram_if.sv
// jimmy_port_ram_if
//   Port-side bundle between the jimmy core and the port RAM responder.
//     addr_in    core out_port_1 (address)
//     wdata_in   core out_port_2 (write data)
//     cmd_in     core out_port_3 (command code)
//     strobe_in  core out_strobe, [1]=addr [2]=wdata [3]=cmd
//     rdata_out  to core in_port_0 (read data)
//     status_out to core in_port_1 (status flags)
//   master = core side, slave = responder side.
interface jimmy_port_ram_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [7:0]        cmd_in;
    logic [3:0]        strobe_in;
    logic [DATA_W-1:0] rdata_out;
    logic [7:0]        status_out;

    modport master (
        output addr_in, wdata_in, cmd_in, strobe_in,
        input  rdata_out, status_out
    );

    modport slave (
        input  addr_in, wdata_in, cmd_in, strobe_in,
        output rdata_out, status_out
    );
endinterface

// File: rtl/jimmy_port_ram_strobe_edge_detect.sv
// strobe_edge_detect
//   Registers a strobe vector and produces a one-cycle pulse per bit on each
//   rising edge. The core holds out_strobe high for an arbitrary time, so only
//   the 0->1 transition marks a new transfer.
//   Ports: clk, reset (sync, active-high), strobe_in[WIDTH], rise[WIDTH].
module strobe_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] strobe_in,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] strobe_q;
    logic [WIDTH-1:0] strobe_d;

    always_comb strobe_d = strobe_in;

    always_ff @(posedge clk) begin
        if (reset) strobe_q <= '0;
        else       strobe_q <= strobe_d;
    end

    assign rise = strobe_in & ~strobe_q;
endmodule

// File: rtl/jimmy_port_ram.sv
// jimmy_port_ram
//   Writable scratch memory answering the jimmy core's port traffic. The core
//   latches an address and write data through out_port_1/2, then issues a
//   command on out_port_3; results come back on in_port_0 (read data) and
//   in_port_1 (status).
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    jimmy_port_ram_if.slave (addr/wdata/cmd/strobe in, rdata/status out)
//   status_out: [0]busy [1]done [2]err_cmd [3]err_range [4]overrun [7:5]=0
module jimmy_port_ram
    import jimmy_port_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    jimmy_port_ram_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // ---------------------------------------------------------------
    // Strobe edges (bit 0 of out_strobe is not ours)
    // ---------------------------------------------------------------
    logic [STB_N-1:0] stb_rise;

    strobe_edge_detect #(.WIDTH(STB_N)) u_edge (
        .clk       (clk),
        .reset     (reset),
        .strobe_in (bus.strobe_in[STB_LO +: STB_N]),
        .rise      (stb_rise)
    );

    logic addr_ev, wdata_ev, cmd_ev;
    assign addr_ev  = stb_rise[STB_ADDR  - STB_LO];
    assign wdata_ev = stb_rise[STB_WDATA - STB_LO];
    assign cmd_ev   = stb_rise[STB_CMD   - STB_LO];

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_cmd_q, err_cmd_d;
    logic              err_range_q, err_range_d;
    logic              overrun_q, overrun_d;
    logic              clr_pend_q, clr_pend_d;   // post-reset sweep owed

    // Single-port memory; the CLR sweep owns the port while it runs
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // A command arriving with a fresh address in the same cycle must use the
    // new value, not the one still sitting in addr_q.
    logic [ADDR_W-1:0] eff_addr;
    logic              addr_oob;

    always_comb begin
        eff_addr = addr_ev ? bus.addr_in : addr_q;
        addr_oob = (32'(eff_addr) >= 32'(DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        clr_cnt_d   = clr_cnt_q;
        rdata_d     = rdata_q;
        done_d      = done_q;
        err_cmd_d   = err_cmd_q;
        err_range_d = err_range_q;
        overrun_d   = overrun_q;
        clr_pend_d  = clr_pend_q;
        mem_we      = 1'b0;
        mem_addr    = addr_q[IDX_W-1:0];
        mem_wdata   = wdata_q;

        // Operand latches run in every state
        if (addr_ev)  addr_d  = bus.addr_in;
        if (wdata_ev) wdata_d = bus.wdata_in;

        unique case (state_q)
            S_IDLE: begin
                if (clr_pend_q) begin
                    // Sweep after reset takes priority; a command that lands
                    // here finds the block already committed to CLR.
                    clr_pend_d = 1'b0;
                    state_d    = S_CLR;
                    clr_cnt_d  = '0;
                    done_d     = 1'b0;
                    if (cmd_ev) overrun_d = 1'b1;
                end else if (cmd_ev) begin
                    case (bus.cmd_in)
                        CMD_READ, CMD_WRITE: begin
                            if (addr_oob) begin
                                err_range_d = 1'b1;
                                done_d      = 1'b1;
                            end else begin
                                state_d = (bus.cmd_in == CMD_READ) ? S_RD : S_WR;
                                done_d  = 1'b0;
                            end
                        end
                        CMD_CLEAR: begin
                            state_d   = S_CLR;
                            clr_cnt_d = '0;
                            done_d    = 1'b0;
                        end
                        CMD_ACK: begin
                            done_d      = 1'b0;
                            err_cmd_d   = 1'b0;
                            err_range_d = 1'b0;
                            overrun_d   = 1'b0;
                        end
                        default: begin
                            err_cmd_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end

            S_RD: begin
                // addr_q already holds the forwarded address from the cmd cycle
                rdata_d = mem[addr_q[IDX_W-1:0]];
                state_d = S_IDLE;
                done_d  = 1'b1;
            end

            S_WR: begin
                mem_we  = 1'b1;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end

            S_CLR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                if (clr_cnt_q == LAST_IDX) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Commands are only taken in IDLE; anything else is lost and flagged
        if (cmd_ev && state_q != S_IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            clr_cnt_q   <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_cmd_q   <= 1'b0;
            err_range_q <= 1'b0;
            overrun_q   <= 1'b0;
            clr_pend_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            clr_cnt_q   <= clr_cnt_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_cmd_q   <= err_cmd_d;
            err_range_q <= err_range_d;
            overrun_q   <= overrun_d;
            clr_pend_q  <= clr_pend_d;
        end
    end

    // Memory contents survive reset; only the sweep clears them
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    logic [7:0] status;

    always_comb begin
        status               = '0;
        status[ST_BUSY]      = (state_q != S_IDLE);
        status[ST_DONE]      = done_q;
        status[ST_ERR_CMD]   = err_cmd_q;
        status[ST_ERR_RANGE] = err_range_q;
        status[ST_OVERRUN]   = overrun_q;
    end

    assign bus.rdata_out  = rdata_q;
    assign bus.status_out = status;

endmodule
